os_generator: RTL and testbench

- TX-side companion to the RX ordered-set checker inside the LTSSM.
- Builds the 128-bit TS1/TS2 ordered set required by the current LTSSM substate and presents it to the serializer over a valid/ready handshake.
- Counts transmitted sets and flags when the spec-minimum transmit counts are met; the main LTSSM uses that flag to gate substate exits.

---
 rtl/os_generator_if.sv | 8 +
 rtl/os_generator.sv | 82 ++++++++
 tb/tb_os_generator.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/os_generator_if.sv
// os_generator_if: ordered-set valid/ready handshake towards the serializer
interface os_generator_if;
  logic [127:0] orderedset;
  logic         valid;
  logic         ready;
  modport master (output orderedset, valid, input ready);
  modport slave (input orderedset, valid, output ready);
endinterface

// File: rtl/os_generator.sv
// os_generator: builds TS1/TS2 ordered sets per LTSSM substate and counts transmitted sets
module os_generator #(
  parameter bit          DEVICETYPE = 1'b0,
  parameter logic [10:0] PA_MIN_TS1 = 11'd1024,
  parameter logic [4:0]  POST_RX_TS = 5'd16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [3:0]         substate,
  input  logic [7:0]         linkNumber,
  input  logic [7:0]         laneNumber,
  input  logic [7:0]         rateid,
  input  logic               upconfigure_capability,
  input  logic               rx_ts_seen,
  os_generator_if.master     bus,
  output logic [10:0]        tx_count,
  output logic               tx_done
);
  localparam logic [7:0] PAD = 8'hF7;
  typedef enum logic [1:0] {IDLE, SEND, STALL} state_t;
  state_t       state;
  logic [3:0]   sub_q;
  logic         armed;
  logic [4:0]   post_cnt;
  logic [127:0] os_q;
  logic         xfer, pending, change, is_tx, is_ts2, done_nxt;
  logic [7:0]   link, lane;
  logic [10:0]  cnt_nxt;
  logic [4:0]   post_nxt;
  logic [127:0] os_nxt;
  assign bus.valid = state != IDLE;
  assign bus.orderedset = os_q;
  // next set content, handshake status and saturating counter increments
  always_comb begin
    xfer = bus.valid && bus.ready;
    pending = bus.valid && !bus.ready;
    change = substate != sub_q;
    is_tx = substate >= 4'd2 && substate <= 4'd8;
    is_ts2 = substate == 4'd3 || substate == 4'd8;
    link = (substate == 4'd2 || substate == 4'd3 || (substate == 4'd4 && DEVICETYPE)) ? PAD : linkNumber;
    lane = (substate <= 4'd4 || (substate == 4'd5 && DEVICETYPE)) ? PAD : laneNumber;
    os_nxt = {{10{is_ts2 ? 8'h25 : 8'h2A}}, 5'b0, upconfigure_capability, 2'b0, rateid, 8'h00,
              lane, link, is_ts2 ? 8'h2D : 8'h1E};
    cnt_nxt = (xfer && tx_count != 11'h7FF) ? tx_count + 11'd1 : tx_count;
    post_nxt = (xfer && armed && post_cnt != 5'h1F) ? post_cnt + 5'd1 : post_cnt;
    done_nxt = (sub_q == 4'd2 && cnt_nxt >= PA_MIN_TS1) ||
               ((sub_q == 4'd3 || sub_q == 4'd8) && post_nxt >= POST_RX_TS);
  end
  // handshake FSM: a stalled set is held bit-stable and defers any substate change
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      os_q <= '0;
      sub_q <= '0;
    end else if (pending) begin
      state <= STALL;
    end else begin
      state <= is_tx ? SEND : IDLE;
      os_q <= os_nxt;
      sub_q <= substate;
    end
  end
  // transmit counters and sticky done flag, cleared on an accepted substate change
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_count <= '0;
      post_cnt <= '0;
      armed <= 1'b0;
      tx_done <= 1'b0;
    end else if (!pending && change) begin
      tx_count <= '0;
      post_cnt <= '0;
      armed <= 1'b0;
      tx_done <= 1'b0;
    end else begin
      tx_count <= cnt_nxt;
      post_cnt <= post_nxt;
      armed <= armed | rx_ts_seen;
      tx_done <= tx_done | done_nxt;
    end
  end
endmodule

// File: tb/tb_os_generator.sv
// tb_os_generator: directed table and sequence checks for os_generator
module tb_os_generator;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [3:0] substate = 4'd0;
  logic [7:0] link_number = 8'h03, lane_number = 8'h01, rateid = 8'h1F;
  logic upcfg = 1'b1, rx_ts_seen = 1'b0;
  logic [10:0] tx_count_dn, tx_count_up;
  logic tx_done_dn, tx_done_up;
  int total = 0, bad = 0;
  os_generator_if bus_dn ();
  os_generator_if bus_up ();
  always #5 clk = ~clk;
  os_generator #(.DEVICETYPE(1'b0)) dut_dn (
    .clk(clk), .reset(reset), .substate(substate), .linkNumber(link_number),
    .laneNumber(lane_number), .rateid(rateid), .upconfigure_capability(upcfg),
    .rx_ts_seen(rx_ts_seen), .bus(bus_dn.master), .tx_count(tx_count_dn), .tx_done(tx_done_dn));
  os_generator #(.DEVICETYPE(1'b1)) dut_up (
    .clk(clk), .reset(reset), .substate(substate), .linkNumber(link_number),
    .laneNumber(lane_number), .rateid(rateid), .upconfigure_capability(upcfg),
    .rx_ts_seen(rx_ts_seen), .bus(bus_up.master), .tx_count(tx_count_up), .tx_done(tx_done_up));
  typedef struct {
    logic [3:0] sub;
    logic       v;
    logic [7:0] b0, dl, dn, ul, un, id;
  } vec_t;
  vec_t tbl[10];
  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  function automatic logic [127:0] mk(input logic [7:0] b0, link, lane, id, rate, input logic up);
    logic [127:0] os;
    os = '0;
    os[7:0] = b0;
    os[15:8] = link;
    os[23:16] = lane;
    os[39:32] = rate;
    os[42] = up;
    for (int k = 6; k < 16; k++) os[8*k +: 8] = id;
    return os;
  endfunction
  task automatic do_reset(input logic [3:0] sub);
    reset = 1'b1;
    step();
    substate = sub;
    reset = 1'b0;
  endtask
  initial begin
    bus_dn.ready = 1'b1;
    bus_up.ready = 1'b1;
    tbl[0] = '{4'd2,  1'b1, 8'h1E, 8'hF7, 8'hF7, 8'hF7, 8'hF7, 8'h2A};
    tbl[1] = '{4'd3,  1'b1, 8'h2D, 8'hF7, 8'hF7, 8'hF7, 8'hF7, 8'h25};
    tbl[2] = '{4'd4,  1'b1, 8'h1E, 8'h03, 8'hF7, 8'hF7, 8'hF7, 8'h2A};
    tbl[3] = '{4'd5,  1'b1, 8'h1E, 8'h03, 8'h01, 8'h03, 8'hF7, 8'h2A};
    tbl[4] = '{4'd6,  1'b1, 8'h1E, 8'h03, 8'h01, 8'h03, 8'h01, 8'h2A};
    tbl[5] = '{4'd7,  1'b1, 8'h1E, 8'h03, 8'h01, 8'h03, 8'h01, 8'h2A};
    tbl[6] = '{4'd8,  1'b1, 8'h2D, 8'h03, 8'h01, 8'h03, 8'h01, 8'h25};
    tbl[7] = '{4'd9,  1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    tbl[8] = '{4'd12, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    tbl[9] = '{4'd0,  1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    step();
    step();
    chk("rst_valid", {127'd0, bus_dn.valid}, 128'd0);
    chk("rst_os", bus_dn.orderedset, 128'd0);
    chk("rst_count", {117'd0, tx_count_dn}, 128'd0);
    chk("rst_done", {127'd0, tx_done_dn}, 128'd0);
    reset = 1'b0;
    step();
    for (int i = 0; i < 10; i++) begin
      substate = tbl[i].sub;
      step();
      chk($sformatf("valid_dn_%0d", tbl[i].sub), {127'd0, bus_dn.valid}, {127'd0, tbl[i].v});
      chk($sformatf("valid_up_%0d", tbl[i].sub), {127'd0, bus_up.valid}, {127'd0, tbl[i].v});
      chk($sformatf("count_%0d", tbl[i].sub), {117'd0, tx_count_dn}, 128'd0);
      chk($sformatf("done_%0d", tbl[i].sub), {127'd0, tx_done_dn}, 128'd0);
      if (tbl[i].v) begin
        chk($sformatf("os_dn_%0d", tbl[i].sub), bus_dn.orderedset,
            mk(tbl[i].b0, tbl[i].dl, tbl[i].dn, tbl[i].id, 8'h1F, 1'b1));
        chk($sformatf("os_up_%0d", tbl[i].sub), bus_up.orderedset,
            mk(tbl[i].b0, tbl[i].ul, tbl[i].un, tbl[i].id, 8'h1F, 1'b1));
      end
      if (tbl[i].sub == 4'd8) begin
        chk("bit42", {127'd0, bus_dn.orderedset[42]}, 128'd1);
        chk("bit43", {127'd0, bus_dn.orderedset[43]}, 128'd0);
        chk("byte4", {120'd0, bus_dn.orderedset[39:32]}, 128'h1F);
      end
    end
    // pollingActive: tx_done after 1024 transfers, count keeps going
    do_reset(4'd2);
    step();
    chk("pa_valid", {127'd0, bus_dn.valid}, 128'd1);
    chk("pa_byte10", {120'd0, bus_dn.orderedset[87:80]}, 128'h2A);
    for (int i = 1; i <= 1030; i++) begin
      step();
      if (i == 1023 || i == 1024) chk($sformatf("pa_done_%0d", i), {127'd0, tx_done_dn}, {127'd0, i >= 1024});
    end
    chk("pa_count", {117'd0, tx_count_dn}, 128'd1030);
    chk("pa_done_sticky", {127'd0, tx_done_dn}, 128'd1);
    // pollingConfiguration: pulse at transfer 5, 16 armed transfers afterwards
    substate = 4'd3;
    step();
    chk("pc_count0", {117'd0, tx_count_dn}, 128'd0);
    chk("pc_byte10", {120'd0, bus_dn.orderedset[87:80]}, 128'h25);
    for (int i = 1; i <= 25; i++) begin
      rx_ts_seen = (i == 5);
      step();
      if (i == 20 || i == 21) chk($sformatf("pc_done_%0d", i), {127'd0, tx_done_dn}, {127'd0, i >= 21});
    end
    rx_ts_seen = 1'b0;
    chk("pc_count", {117'd0, tx_count_dn}, 128'd25);
    // stall in cfgLinkWidthStart with a deferred change to cfgLinkWidthAccept
    substate = 4'd4;
    step();
    step();
    step();
    chk("st_count_pre", {117'd0, tx_count_dn}, 128'd2);
    bus_dn.ready = 1'b0;
    substate = 4'd5;
    link_number = 8'h09;
    for (int i = 0; i < 5; i++) begin
      step();
      chk($sformatf("st_frozen_%0d", i), bus_dn.orderedset, mk(8'h1E, 8'h03, 8'hF7, 8'h2A, 8'h1F, 1'b1));
      chk($sformatf("st_valid_%0d", i), {127'd0, bus_dn.valid}, 128'd1);
    end
    chk("st_count_hold", {117'd0, tx_count_dn}, 128'd2);
    bus_dn.ready = 1'b1;
    step();
    chk("st_new_os", bus_dn.orderedset, mk(8'h1E, 8'h09, 8'h01, 8'h2A, 8'h1F, 1'b1));
    chk("st_new_count", {117'd0, tx_count_dn}, 128'd0);
    // asynchronous reset while stalled
    substate = 4'd6;
    step();
    for (int i = 0; i < 7; i++) step();
    bus_dn.ready = 1'b0;
    step();
    chk("ar_count_pre", {117'd0, tx_count_dn}, 128'd7);
    chk("ar_valid_pre", {127'd0, bus_dn.valid}, 128'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("ar_valid", {127'd0, bus_dn.valid}, 128'd0);
    chk("ar_count", {117'd0, tx_count_dn}, 128'd0);
    chk("ar_os", bus_dn.orderedset, 128'd0);
    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
